// File: rtl/cache_pkg.sv
// Shared cache constants, line-controller state type and address-split helpers.
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 26;
  localparam int INDEX_W    = 2;
  localparam int OFFSET_W   = 4;
  localparam int BEAT_W     = 2;
  localparam logic [ADDR_W-1:0] MMIO_BASE = 32'h0001_0000;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE,
    S_HOLD
  } line_ctrl_state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  function automatic logic [ADDR_W-1:0] wb_base(input logic [TAG_W-1:0]  tag,
                                                input logic [ADDR_W-1:0] addr);
    return {tag, addr[OFFSET_W+INDEX_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  // Bases are line-aligned, so the beat index simply replaces the word-offset bits.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    return {base[ADDR_W-1:OFFSET_W], beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_line_ctrl.sv
// Miss service controller: optional dirty-victim writeback, then line fill, then a
// single update pulse; all outputs are registered.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int                ADDR_W_P    = ADDR_W,
  parameter logic [ADDR_W-1:0] MMIO_BASE_P = MMIO_BASE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_miss,
  input  logic                i_dirty,
  input  logic [ADDR_W_P-1:0] i_fill_addr,
  input  logic [TAG_W-1:0]    i_victim_tag,
  input  logic [31:0]         i_ow0,
  input  logic [31:0]         i_ow1,
  input  logic [31:0]         i_ow2,
  input  logic [31:0]         i_ow3,
  output logic [31:0]         o_w0,
  output logic [31:0]         o_w1,
  output logic [31:0]         o_w2,
  output logic [31:0]         o_w3,
  output logic                o_update,
  output logic                o_busy,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W_P-1:0] o_mem_addr,
  output logic [31:0]         o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [31:0]         i_mem_rdata
);

  line_ctrl_state_t    r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_line_base;
  logic [ADDR_W-1:0]   r_wb_base;
  word_t               r_ow [LINE_WORDS];
  word_t               r_w  [LINE_WORDS];
  logic                r_update;
  logic                r_busy;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  word_t               r_mem_wdata;

  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                w_capture;

  assign w_beat_nxt = r_beat + 1'b1;
  assign w_capture  = i_miss && (i_fill_addr < MMIO_BASE_P);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_line_base <= '0;
      r_wb_base   <= '0;
      r_ow        <= '{default: '0};
      r_w         <= '{default: '0};
      r_update    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_line_base <= line_base(i_fill_addr);
            r_wb_base   <= wb_base(i_victim_tag, i_fill_addr);
            r_ow        <= '{i_ow0, i_ow1, i_ow2, i_ow3};
            r_beat      <= '0;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_dirty;
            r_mem_addr  <= i_dirty ? wb_base(i_victim_tag, i_fill_addr)
                                   : line_base(i_fill_addr);
            r_mem_wdata <= i_dirty ? i_ow0 : '0;
            r_state     <= i_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (i_mem_ack) begin
            r_beat <= w_beat_nxt;
            if (r_beat == LAST_BEAT) begin
              r_state     <= S_FILL;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= r_line_base;
              r_mem_wdata <= '0;
            end else begin
              r_mem_addr  <= beat_addr(r_wb_base, w_beat_nxt);
              r_mem_wdata <= r_ow[w_beat_nxt];
            end
          end
        end
        S_FILL: begin
          if (i_mem_ack) begin
            r_w[r_beat] <= i_mem_rdata;
            r_beat      <= w_beat_nxt;
            if (r_beat == LAST_BEAT) begin
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
              r_update  <= 1'b1;
            end else begin
              r_mem_addr <= beat_addr(r_line_base, w_beat_nxt);
            end
          end
        end
        S_DONE: r_state <= S_HOLD;
        // Wait for the cache to drop miss so the same miss is not serviced twice.
        S_HOLD: begin
          if (!i_miss) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_w0        = r_w[0];
  assign o_w1        = r_w[1];
  assign o_w2        = r_w[2];
  assign o_w3        = r_w[3];
  assign o_update    = r_update;
  assign o_busy      = r_busy;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/cache_line_ctrl.md
# cache_line_ctrl

Memory-side line-transfer controller for the 4-way set-associative data cache. It services a cache miss by first writing back the dirty victim line (ow0–ow3) to main memory, word by word. It then fetches the missing 16-byte line one word at a time. Finally it presents the assembled line on w0–w3 with a one-cycle `update` pulse. It sits between the cache and the single-port word memory and owns the memory request handshake.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_WORDS`, 4, words per line (fixed; beat counter is 2 bits)
- `MMIO_BASE`, 32'h0001_0000, first memory-mapped IO address; never serviced
- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  reset, asynchronous, active-low
- `miss`  in  1  level; cache requests line service; held until `update` seen
- `dirty`  in  1  victim way valid and dirty; sampled with `miss`
- `fill_addr`  in  32  missing address; line base = {fill_addr[31:4], 4'b0}
- `victim_tag`  in  26  tag of victim; writeback base = {victim_tag, fill_addr[5:4], 4'b0}
- `ow0`..`ow3`  in  32 each  victim line, owN = word at base+4N
- `w0`..`w3`  out  32 each  fetched line, wN = word at base+4N
- `update`  out  1  one-cycle pulse; w0–w3 valid this cycle and held after
- `busy`  out  1  high from capture edge until return to IDLE
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write beat, 0 = read beat
- `mem_addr`  out  32  word-aligned beat address
- `mem_wdata`  out  32  write data
- `mem_ack`  in  1  memory completes the current beat this cycle
- `mem_rdata`  in  32  read data, valid when `mem_ack` and `!mem_we`

## Operation
- States: IDLE, WB, FILL, DONE, HOLD.
- IDLE:
  - When `miss` is high and `fill_addr < MMIO_BASE`, capture `fill_addr`, `victim_tag`, `dirty`, and ow0–ow3 into internal registers.
  - Clear the beat counter.
  - Go to WB if `dirty`, else to FILL.
  - If `miss` is high and `fill_addr >= MMIO_BASE`, ignore it and stay in IDLE.
- WB:
  - `mem_req`=1, `mem_we`=1, `mem_addr`=wb_base+4·beat, `mem_wdata`=captured ow[beat].
  - On `mem_ack`: beat+1. On the ack of beat 3: beat wraps to 0 and go to FILL.
- FILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=line_base+4·beat.
  - On `mem_ack`: w[beat] <= `mem_rdata`; beat+1. On the ack of beat 3: go to DONE.
- DONE: `update`=1 for exactly this cycle; go to HOLD.
- HOLD: wait for `miss`=0, then go to IDLE. This prevents re-servicing the same miss.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable while `mem_req` is high and `mem_ack` is low.
- Fields change only on the edge after an ack. `mem_req` stays high across consecutive beats.
- `mem_ack` in IDLE, DONE or HOLD is ignored.
- Input changes on `fill_addr`, `dirty` or ow* after capture have no effect.
- All outputs are registered or decoded from registered state only. There is no combinational path from `mem_ack` or `miss` to any output.

## Timing
- Reset (RST=0, async): state IDLE; beat 0; all outputs 0, including w0–w3, `mem_addr` and `mem_wdata`.
- Reset mid-transfer abandons the transfer. `mem_req` drops immediately. Partial w0–w3 contents are cleared.
- Capture edge = edge T at which IDLE samples a valid `miss`. `busy` and `mem_req` are high from T.
- With `mem_ack` tied high (zero-wait memory):
  - Clean miss: FILL beats at T..T+3, `update` at T+4, HOLD from T+5.
  - Dirty miss: WB beats at T..T+3, FILL at T+4..T+7, `update` at T+8.
- Each wait cycle (`mem_ack`=0) adds exactly one cycle. There is no timeout.
- `busy` falls on the edge HOLD sees `miss`=0. A new miss is capturable on the following edge at the earliest.

## Structure
- Shared package `cache_pkg`:
  - Constants: `LINE_WORDS`, `TAG_W`=26, `INDEX_W`=2, `OFFSET_W`=4, `MMIO_BASE`.
  - State enum typedef `line_ctrl_state_t`.
  - Address-split helper functions for line base and writeback base.
- Single module; FSM, beat counter and line registers inline. No sub-module is natural.

## Test plan
- Clean miss: `fill_addr`=0x0000_1234, `dirty`=0, ack always 1, rdata = 0xA0, 0xA1, 0xA2, 0xA3 → read addrs 0x1230, 0x1234, 0x1238, 0x123C; `update` at T+4 with w0..w3 = 0xA0..0xA3.
- Dirty miss: `victim_tag`=26'h5, `fill_addr`=0x20, ow0..ow3 = 0x11..0x44 → writes to 0x160, 0x164, 0x168, 0x16C with 0x11..0x44, then reads 0x20..0x2C; `update` at T+8.
- Wait states: ack low for 2 cycles on every beat of a clean miss → `mem_addr` held stable while ack is low; `update` at T+12; spurious ack in HOLD ignored.
- MMIO/hold: `miss`=1 with `fill_addr`=0x0001_0000 → stays IDLE, `busy`=0. Valid miss with `miss` held 5 cycles after `update` → exactly one `update`; HOLD until `miss` falls.
- Reset mid-FILL: RST=0 after beat 1 ack → `mem_req`, `busy` and w0–w3 go 0 immediately. After release, a fresh miss completes normally.
